sensor_stream_mon: RTL and testbench

- Passive, synthesizable multi-channel monitor for sensor sample streams (LiDAR, radar, IMU) on valid/ready links.
- Generalises the single-channel LiDAR sample monitor: parametrised channel count and data width.
- Per channel it tracks sample count, min/max/last value, range violations, handshake-protocol errors and stream timeouts.
- Results are exposed through a registered per-channel readout port plus an aggregate interrupt; optional simulation logging.

---
 rtl/sensor_stream_mon_pkg.sv | 33 +++
 rtl/sensor_stream_mon_if.sv | 14 +
 rtl/sensor_stream_mon_ch_stats.sv | 121 ++++++++++++
 rtl/sensor_stream_mon.sv | 109 ++++++++++
 tb/tb_sensor_stream_mon.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_stream_mon_pkg.sv
// Shared types for the sensor stream monitor: channel state codes, flag bit
// positions and the per-channel statistics record.
package sensor_mon_pkg;

  localparam int MAX_DATA_W = 32;
  localparam int MAX_CNT_W  = 32;
  localparam int NUM_FLAGS  = 4;

  localparam int FLG_SAT   = 0;
  localparam int FLG_RANGE = 1;
  localparam int FLG_PROTO = 2;
  localparam int FLG_TO    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    TIMEOUT = 2'd2
  } ch_state_e;

  // Widths are the largest supported; narrower channels zero-extend into it.
  typedef struct packed {
    logic [MAX_CNT_W-1:0]  count;
    logic [MAX_DATA_W-1:0] min_val;
    logic [MAX_DATA_W-1:0] max_val;
    logic [MAX_DATA_W-1:0] last_val;
    logic [NUM_FLAGS-1:0]  flags;
  } ch_stats_t;

  function automatic logic err_flags_set(logic [NUM_FLAGS-1:0] f);
    return f[FLG_RANGE] | f[FLG_PROTO] | f[FLG_TO];
  endfunction

endpackage

// File: rtl/sensor_stream_mon_if.sv
// Bundle of per-channel valid/ready sample links watched by the monitor.
interface sensor_stream_if
  import sensor_mon_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 16
);
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;

  modport master (output ch_data, ch_valid, ch_ready);
  modport slave  (input  ch_data, ch_valid, ch_ready);
endinterface

// File: rtl/sensor_stream_mon_ch_stats.sv
// Single-channel tracker: sample statistics, range and handshake checks, and
// the IDLE/ACTIVE/TIMEOUT activity FSM with its idle timer.
module sensor_ch_stats
  import sensor_mon_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       CNT_W    = 32,
  parameter int unsigned       TO_CYC   = 1024,
  parameter logic [DATA_W-1:0] RANGE_LO = '0,
  parameter logic [DATA_W-1:0] RANGE_HI = '1,
  parameter bit                LOG_EN   = 1'b0,
  parameter int unsigned       CH_ID    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mon_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic              ready,
  output ch_stats_t         stats,
  output ch_state_e         state
);

  localparam int TMR_W = $clog2(TO_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0]     count_q;
  logic [DATA_W-1:0]    min_q, max_q, last_q, prev_data;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [TMR_W-1:0]     timer_q;
  logic                 prev_valid, prev_ready;
  logic                 accept, proto_viol, lo_bad, hi_bad;

  assign accept = valid & ready & mon_en;
  // A stalled transfer must neither be withdrawn nor have its payload altered.
  assign proto_viol = mon_en & prev_valid & ~prev_ready & (~valid | (data != prev_data));

  if (RANGE_LO != '0) begin : g_lo
    assign lo_bad = data < RANGE_LO;
  end else begin : g_no_lo
    assign lo_bad = 1'b0;
  end

  if (RANGE_HI != '1) begin : g_hi
    assign hi_bad = data > RANGE_HI;
  end else begin : g_no_hi
    assign hi_bad = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0; min_q <= '1; max_q <= '0; last_q <= '0; flags_q <= '0;
      timer_q <= '0; state <= IDLE;
      prev_valid <= 1'b0; prev_ready <= 1'b0; prev_data <= '0;
    end else if (clr) begin
      count_q <= '0; min_q <= '1; max_q <= '0; last_q <= '0; flags_q <= '0;
      timer_q <= '0; state <= IDLE;
      prev_valid <= 1'b0; prev_ready <= 1'b0; prev_data <= '0;
    end else begin
      prev_valid <= valid;
      prev_ready <= ready;
      prev_data  <= data;
      if (proto_viol) flags_q[FLG_PROTO] <= 1'b1;
      if (accept) begin
        if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
        if (count_q >= CNT_MAX - 1'b1) flags_q[FLG_SAT] <= 1'b1;
        if (data < min_q) min_q <= data;
        if (data > max_q) max_q <= data;
        last_q <= data;
        if (lo_bad | hi_bad) flags_q[FLG_RANGE] <= 1'b1;
      end
      // Timer only runs while ACTIVE and monitoring is enabled.
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= ACTIVE;
            timer_q <= '0;
          end
        end
        ACTIVE: begin
          if (accept) begin
            timer_q <= '0;
          end else if (mon_en) begin
            if (timer_q == TMR_LAST) begin
              state            <= TIMEOUT;
              flags_q[FLG_TO]  <= 1'b1;
              timer_q          <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        TIMEOUT: begin
          if (accept) begin
            state   <= ACTIVE;
            timer_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stats = '{count:    MAX_CNT_W'(count_q),
                   min_val:  MAX_DATA_W'(min_q),
                   max_val:  MAX_DATA_W'(max_q),
                   last_val: MAX_DATA_W'(last_q),
                   flags:    flags_q};

`ifndef SYNTHESIS
  if (LOG_EN) begin : g_log
    always_ff @(posedge clk) begin
      if (rst_n && !clr && accept)
        $display("[%0t] ch%0d sample %0d data %0d", $time, CH_ID, count_q, data);
    end
  end
`endif

endmodule

// File: rtl/sensor_stream_mon.sv
// Multi-channel passive stream monitor: one tracker per channel, a registered
// per-channel readout port and a sticky aggregate error interrupt.
module sensor_stream_mon
  import sensor_mon_pkg::*;
#(
  parameter int unsigned       NUM_CH   = 4,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       CNT_W    = 32,
  parameter int unsigned       TO_CYC   = 1024,
  parameter logic [DATA_W-1:0] RANGE_LO = '0,
  parameter logic [DATA_W-1:0] RANGE_HI = '1,
  parameter bit                LOG_EN   = 1'b0,
  localparam int               RD_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mon_en,
  input  logic                 clr,
  sensor_stream_if.slave       stream,
  input  logic [RD_W-1:0]      rd_ch,
  output logic [CNT_W-1:0]     rd_count,
  output logic [DATA_W-1:0]    rd_min,
  output logic [DATA_W-1:0]    rd_max,
  output logic [DATA_W-1:0]    rd_last,
  output logic [NUM_FLAGS-1:0] rd_flags,
  output logic [1:0]           rd_state,
  output logic                 irq
);

  localparam int RD_DEPTH = 2 ** RD_W;

  ch_stats_t  stats  [NUM_CH];
  ch_state_e  states [NUM_CH];
  ch_stats_t  rd_tab [RD_DEPTH];
  logic [1:0] rd_st_tab [RD_DEPTH];
  ch_stats_t  rd_sel;
  logic [1:0] rd_st_sel;
  logic       any_err;
  logic       unused_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sensor_ch_stats #(
      .DATA_W  (DATA_W),
      .CNT_W   (CNT_W),
      .TO_CYC  (TO_CYC),
      .RANGE_LO(RANGE_LO),
      .RANGE_HI(RANGE_HI),
      .LOG_EN  (LOG_EN),
      .CH_ID   (i)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .mon_en(mon_en),
      .clr   (clr),
      .data  (stream.ch_data[i*DATA_W +: DATA_W]),
      .valid (stream.ch_valid[i]),
      .ready (stream.ch_ready[i]),
      .stats (stats[i]),
      .state (states[i])
    );
  end

  // Unpopulated select codes read back as an all-zero record.
  always_comb begin
    for (int j = 0; j < RD_DEPTH; j++) begin
      rd_tab[j]    = '0;
      rd_st_tab[j] = 2'b00;
    end
    any_err = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      rd_tab[j]    = stats[j];
      rd_st_tab[j] = states[j];
      any_err      = any_err | err_flags_set(stats[j].flags);
    end
  end

  assign rd_sel     = rd_tab[rd_ch];
  assign rd_st_sel  = rd_st_tab[rd_ch];
  assign unused_sel = ^rd_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      rd_min   <= '0;
      rd_max   <= '0;
      rd_last  <= '0;
      rd_flags <= '0;
      rd_state <= 2'b00;
    end else begin
      rd_count <= rd_sel.count[CNT_W-1:0];
      rd_min   <= rd_sel.min_val[DATA_W-1:0];
      rd_max   <= rd_sel.max_val[DATA_W-1:0];
      rd_last  <= rd_sel.last_val[DATA_W-1:0];
      rd_flags <= rd_sel.flags;
      rd_state <= rd_st_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (clr) begin
      irq <= 1'b0;
    end else if (any_err) begin
      irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sensor_stream_mon.sv
// Scoreboard bench for sensor_stream_mon: two configurations, reads queued
// with expected records and checked by per-instance monitor processes.
module tb_sensor_stream_mon;
  import sensor_mon_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_ACT = 2'd1, ST_TO = 2'd2;

  typedef struct packed {
    logic [31:0] count;
    logic [15:0] mn;
    logic [15:0] mx;
    logic [15:0] last;
    logic [3:0]  flags;
    logic [1:0]  state;
    logic        irq;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mon_en_a, clr_a, mon_en_b, clr_b;
  logic rd_req_a, rd_req_b;
  logic [2:0]  rd_ch_a;
  logic [0:0]  rd_ch_b;
  logic [31:0] rd_count_a;
  logic [15:0] rd_min_a, rd_max_a, rd_last_a;
  logic [3:0]  rd_flags_a, rd_flags_b;
  logic [1:0]  rd_state_a, rd_state_b;
  logic        irq_a, irq_b;
  logic [3:0]  rd_count_b;
  logic [7:0]  rd_min_b, rd_max_b, rd_last_b;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q_a[$], q_b[$];
  string nq_a[$], nq_b[$];

  sensor_stream_if #(.NUM_CH(5), .DATA_W(16)) if_a ();
  sensor_stream_if #(.NUM_CH(1), .DATA_W(8))  if_b ();

  sensor_stream_mon #(
    .NUM_CH(5), .DATA_W(16), .CNT_W(32), .TO_CYC(8),
    .RANGE_LO(16'd0), .RANGE_HI(16'd1000), .LOG_EN(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .mon_en(mon_en_a), .clr(clr_a), .stream(if_a),
    .rd_ch(rd_ch_a), .rd_count(rd_count_a), .rd_min(rd_min_a), .rd_max(rd_max_a),
    .rd_last(rd_last_a), .rd_flags(rd_flags_a), .rd_state(rd_state_a), .irq(irq_a)
  );

  sensor_stream_mon #(
    .NUM_CH(1), .DATA_W(8), .CNT_W(4), .TO_CYC(1024), .LOG_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .mon_en(mon_en_b), .clr(clr_b), .stream(if_b),
    .rd_ch(rd_ch_b), .rd_count(rd_count_b), .rd_min(rd_min_b), .rd_max(rd_max_b),
    .rd_last(rd_last_b), .rd_flags(rd_flags_b), .rd_state(rd_state_b), .irq(irq_b)
  );

  function automatic exp_t mk(logic [31:0] c_i, logic [15:0] mn_i, logic [15:0] mx_i,
                              logic [15:0] ls_i, logic [3:0] f_i, logic [1:0] st_i,
                              logic irq_i);
    mk = '{count: c_i, mn: mn_i, mx: mx_i, last: ls_i, flags: f_i, state: st_i, irq: irq_i};
  endfunction

  task automatic check_output(string name, exp_t act, exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got cnt=%0d min=%0d max=%0d last=%0d flags=%b state=%0d irq=%b, want cnt=%0d min=%0d max=%0d last=%0d flags=%b state=%0d irq=%b",
               name, act.count, act.mn, act.mx, act.last, act.flags, act.state, act.irq,
               exp.count, exp.mn, exp.mx, exp.last, exp.flags, exp.state, exp.irq);
    end
  endtask

  task automatic apply_stimulus(int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_a(int ch, string name, exp_t exp);
    rd_ch_a  = 3'(ch);
    rd_req_a = 1'b1;
    q_a.push_back(exp);
    nq_a.push_back(name);
    apply_stimulus(1);
    rd_req_a = 1'b0;
  endtask

  task automatic read_b(int ch, string name, exp_t exp);
    rd_ch_b  = 1'(ch);
    rd_req_b = 1'b1;
    q_b.push_back(exp);
    nq_b.push_back(name);
    apply_stimulus(1);
    rd_req_b = 1'b0;
  endtask

  task automatic accept_a(int ch, logic [15:0] d);
    if_a.ch_data[ch*16 +: 16] = d;
    if_a.ch_valid[ch] = 1'b1;
    if_a.ch_ready[ch] = 1'b1;
    apply_stimulus(1);
    if_a.ch_valid[ch] = 1'b0;
    if_a.ch_ready[ch] = 1'b0;
  endtask

  task automatic accept_b(logic [7:0] d);
    if_b.ch_data  = d;
    if_b.ch_valid = 1'b1;
    if_b.ch_ready = 1'b1;
    apply_stimulus(1);
    if_b.ch_valid = 1'b0;
    if_b.ch_ready = 1'b0;
  endtask

  task automatic pulse_clr_a();
    clr_a = 1'b1;
    apply_stimulus(1);
    clr_a = 1'b0;
  endtask

  initial begin : mon_a
    logic seen;
    exp_t e, act;
    string nm;
    forever begin
      @(posedge clk);
      seen = rd_req_a;
      @(negedge clk);
      if (seen) begin
        if (q_a.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL queue_a: got readout with empty queue, want a queued entry");
        end else begin
          e   = q_a.pop_front();
          nm  = nq_a.pop_front();
          act = mk(rd_count_a, rd_min_a, rd_max_a, rd_last_a, rd_flags_a, rd_state_a, irq_a);
          check_output(nm, act, e);
        end
      end
    end
  end

  initial begin : mon_b
    logic seen;
    exp_t e, act;
    string nm;
    forever begin
      @(posedge clk);
      seen = rd_req_b;
      @(negedge clk);
      if (seen) begin
        if (q_b.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL queue_b: got readout with empty queue, want a queued entry");
        end else begin
          e   = q_b.pop_front();
          nm  = nq_b.pop_front();
          act = mk(32'(rd_count_b), 16'(rd_min_b), 16'(rd_max_b), 16'(rd_last_b),
                   rd_flags_b, rd_state_b, irq_b);
          check_output(nm, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no completion, want finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    logic [15:0] m_min [5];
    logic [15:0] m_max [5];
    logic [15:0] m_last [5];
    logic [15:0] d;
    exp_t zero;

    zero = mk(0, 0, 0, 0, 4'b0000, ST_IDLE, 1'b0);
    rst_n = 1'b0; mon_en_a = 1'b0; clr_a = 1'b0; mon_en_b = 1'b0; clr_b = 1'b0;
    rd_req_a = 1'b0; rd_req_b = 1'b0; rd_ch_a = '0; rd_ch_b = '0;
    if_a.ch_data = '0; if_a.ch_valid = '0; if_a.ch_ready = '0;
    if_b.ch_data = '0; if_b.ch_valid = '0; if_b.ch_ready = '0;

    apply_stimulus(2);
    read_a(0, "reset_state", zero);
    rst_n = 1'b1; mon_en_a = 1'b1; mon_en_b = 1'b1;
    read_a(0, "fresh_ch0", mk(0, 16'hFFFF, 0, 0, 4'b0000, ST_IDLE, 1'b0));

    $display("[TB] basic statistics on channel 0");
    accept_a(0, 16'd10);
    accept_a(0, 16'd500);
    accept_a(0, 16'd3);
    read_a(0, "stats_ch0", mk(3, 3, 500, 3, 4'b0000, ST_ACT, 1'b0));
    pulse_clr_a();

    $display("[TB] range check on channel 1");
    accept_a(1, 16'd1000);
    read_a(1, "range_edge", mk(1, 1000, 1000, 1000, 4'b0000, ST_ACT, 1'b0));
    accept_a(1, 16'd1001);
    read_a(1, "range_err", mk(2, 1000, 1001, 1001, 4'b0010, ST_ACT, 1'b1));
    pulse_clr_a();
    read_a(1, "range_clr", mk(0, 16'hFFFF, 0, 0, 4'b0000, ST_IDLE, 1'b0));

    $display("[TB] protocol checks on channel 2");
    if_a.ch_data[32 +: 16] = 16'd5; if_a.ch_valid[2] = 1'b1; if_a.ch_ready[2] = 1'b0;
    apply_stimulus(1);
    if_a.ch_data[32 +: 16] = 16'd6;
    apply_stimulus(1);
    if_a.ch_valid[2] = 1'b0;
    apply_stimulus(1);
    read_a(2, "proto_data", mk(0, 16'hFFFF, 0, 0, 4'b0100, ST_IDLE, 1'b1));
    pulse_clr_a();

    if_a.ch_data[32 +: 16] = 16'd5; if_a.ch_valid[2] = 1'b1;
    apply_stimulus(1);
    if_a.ch_valid[2] = 1'b0;
    apply_stimulus(1);
    read_a(2, "proto_drop", mk(0, 16'hFFFF, 0, 0, 4'b0100, ST_IDLE, 1'b1));
    pulse_clr_a();

    if_a.ch_data[32 +: 16] = 16'd5; if_a.ch_valid[2] = 1'b1;
    apply_stimulus(1);
    if_a.ch_ready[2] = 1'b1;
    apply_stimulus(1);
    if_a.ch_valid[2] = 1'b0; if_a.ch_ready[2] = 1'b0;
    read_a(2, "proto_legal_stall", mk(1, 5, 5, 5, 4'b0000, ST_ACT, 1'b0));
    pulse_clr_a();

    mon_en_a = 1'b0;
    if_a.ch_data[32 +: 16] = 16'd5; if_a.ch_valid[2] = 1'b1;
    apply_stimulus(1);
    if_a.ch_data[32 +: 16] = 16'd6;
    apply_stimulus(1);
    if_a.ch_valid[2] = 1'b0;
    apply_stimulus(1);
    mon_en_a = 1'b1;
    read_a(2, "proto_disabled", mk(0, 16'hFFFF, 0, 0, 4'b0000, ST_IDLE, 1'b0));

    $display("[TB] timeout on channel 3");
    accept_a(3, 16'd7);
    apply_stimulus(7);
    read_a(3, "timer_edge", mk(1, 7, 7, 7, 4'b0000, ST_ACT, 1'b0));
    read_a(3, "timeout", mk(1, 7, 7, 7, 4'b1000, ST_TO, 1'b1));
    accept_a(3, 16'd9);
    read_a(3, "timeout_resume", mk(2, 7, 9, 9, 4'b1000, ST_ACT, 1'b1));
    read_a(4, "idle_no_timeout", mk(0, 16'hFFFF, 0, 0, 4'b0000, ST_IDLE, 1'b1));
    pulse_clr_a();

    $display("[TB] counter saturation on narrow instance");
    for (int k = 1; k <= 14; k++) accept_b(8'(k));
    read_b(0, "count_14", mk(14, 1, 14, 14, 4'b0000, ST_ACT, 1'b0));
    for (int k = 15; k <= 20; k++) accept_b(8'(k));
    read_b(0, "saturated", mk(15, 1, 20, 20, 4'b0001, ST_ACT, 1'b0));
    clr_b = 1'b1;
    apply_stimulus(1);
    if_b.ch_data = 8'd50; if_b.ch_valid = 1'b1; if_b.ch_ready = 1'b1;
    apply_stimulus(1);
    clr_b = 1'b0; if_b.ch_valid = 1'b0; if_b.ch_ready = 1'b0;
    read_b(0, "clr_beats_accept", mk(0, 16'h00FF, 0, 0, 4'b0000, ST_IDLE, 1'b0));
    read_b(1, "rd_oob_b", zero);

    $display("[TB] all-channel burst");
    for (int i = 0; i < 5; i++) begin
      m_min[i] = 16'hFFFF; m_max[i] = 16'h0000; m_last[i] = 16'h0000;
    end
    if_a.ch_valid = '1; if_a.ch_ready = '1;
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 5; i++) begin
        d = 16'((k * 37 + i * 101 + 13) % 1000);
        if_a.ch_data[i*16 +: 16] = d;
        if (d < m_min[i]) m_min[i] = d;
        if (d > m_max[i]) m_max[i] = d;
        m_last[i] = d;
      end
      apply_stimulus(1);
    end
    if_a.ch_valid = '0; if_a.ch_ready = '0;
    for (int i = 0; i < 5; i++)
      read_a(i, $sformatf("burst_ch%0d", i), mk(100, m_min[i], m_max[i], m_last[i], 4'b0000, ST_ACT, 1'b0));
    read_a(5, "rd_oob_a", zero);

    $display("[TB] asynchronous reset mid-burst");
    rd_ch_a = 3'd0;
    if_a.ch_data = {5{16'd42}}; if_a.ch_valid = '1; if_a.ch_ready = '1;
    apply_stimulus(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", mk(rd_count_a, rd_min_a, rd_max_a, rd_last_a, rd_flags_a, rd_state_a, irq_a), zero);
    apply_stimulus(2);
    if_a.ch_valid = '0; if_a.ch_ready = '0;
    rst_n = 1'b1;
    read_a(0, "post_reset", mk(0, 16'hFFFF, 0, 0, 4'b0000, ST_IDLE, 1'b0));

    apply_stimulus(3);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL drain: got %0d/%0d pending reads, want 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
